// File: rtl/slice_serializer.sv
// slice_serializer: takes a packed word of NUM_SLICES slices and emits
// slices 0..in_len one per downstream handshake. The next word can be
// accepted in the same cycle as the last slice, so back-to-back words
// stream with no bubble.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no word held, out_valid low, in_ready high
// ST_SEND | word held, out_valid high, slice[index] presented
module slice_serializer #(
    parameter  int SLICE_WIDTH      = 4,
    parameter  int SELECT_BUS_WIDTH = 3,
    localparam int NUM_SLICES       = 2 ** SELECT_BUS_WIDTH,
    localparam int INPUT_WIDTH      = SLICE_WIDTH * NUM_SLICES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INPUT_WIDTH-1:0]      in_data,
    input  logic [SELECT_BUS_WIDTH-1:0] in_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [SLICE_WIDTH-1:0]      out_data,
    output logic [SELECT_BUS_WIDTH-1:0] out_index,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [INPUT_WIDTH-1:0]      held_data;
    logic [INPUT_WIDTH-1:0]      held_data_nxt;
    logic [SELECT_BUS_WIDTH-1:0] held_len;
    logic [SELECT_BUS_WIDTH-1:0] held_len_nxt;
    logic [SELECT_BUS_WIDTH-1:0] index;
    logic [SELECT_BUS_WIDTH-1:0] index_nxt;

    logic [SLICE_WIDTH-1:0]      held_slices [NUM_SLICES];

    logic                        send_active;
    logic                        at_last;
    logic                        slice_take;
    logic                        word_accept;

    // View the held word as an array of slices so the output mux indexes
    // directly with the slice counter.
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_unpack
        assign held_slices[k] = held_data[k*SLICE_WIDTH +: SLICE_WIDTH];
    end

    // Handshake qualifiers; reset forces every output quiet immediately,
    // so no slice or word can be exchanged on a reset cycle.
    always_comb begin
        send_active = (state == ST_SEND) && !rst;
        at_last     = (index == held_len);
        slice_take  = send_active && out_ready;
        in_ready    = !rst && ((state == ST_IDLE) || (slice_take && at_last));
        word_accept = in_valid && in_ready;
    end

    // Output drive: purely from held registers, zero when nothing is held.
    always_comb begin
        out_valid = send_active;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (send_active) begin
            out_data  = held_slices[index];
            out_index = index;
            out_last  = at_last;
        end
    end

    // Next-state logic: load on accept, step the index on each non-final
    // slice, and either reload or fall back to idle on the final slice.
    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        held_data_nxt = held_data;
        held_len_nxt  = held_len;
        case (state)
            ST_IDLE: begin
                if (word_accept) begin
                    state_nxt     = ST_SEND;
                    index_nxt     = '0;
                    held_data_nxt = in_data;
                    held_len_nxt  = in_len;
                end
            end
            ST_SEND: begin
                if (slice_take) begin
                    if (!at_last) begin
                        // index < held_len here, so the increment cannot wrap
                        index_nxt = index + SELECT_BUS_WIDTH'(1);
                    end else if (word_accept) begin
                        index_nxt     = '0;
                        held_data_nxt = in_data;
                        held_len_nxt  = in_len;
                    end else begin
                        state_nxt = ST_IDLE;
                        index_nxt = '0;
                    end
                end
            end
        endcase
    end

    // State and holding registers with synchronous reset; reset wins over
    // any handshake pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            index     <= '0;
            held_data <= '0;
            held_len  <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            held_data <= held_data_nxt;
            held_len  <= held_len_nxt;
        end
    end

endmodule
